// File: rtl/uart_transmitter_if.sv
// Byte-source to transmitter handshake plus the serial line and status outputs.
// The host drives through master; the transmitter drives through slave.
interface uart_transmitter_if;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       txOut;
  logic       busy;
  logic       done;

  modport master (output txData, txValid, input txReady, txOut, busy, done);
  modport slave  (input txData, txValid, output txReady, txOut, busy, done);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits.
// Each bit is held for CLKS_PER_BIT clocks; back-to-back frames have no idle gap.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  uart_transmitter_if.slave  tx
);
  localparam int BW = ($clog2(CLKS_PER_BIT + 1) < 1) ? 1 : $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {IDLE, START, SEND, STOP} state_t;

  state_t        state, nxt_state;
  logic [7:0]    shreg, nxt_shreg;
  logic [2:0]    bitcnt, nxt_bitcnt;
  logic [BW-1:0] baud, nxt_baud;
  logic          stopcnt, nxt_stopcnt;
  logic          txout_q, nxt_txout;
  logic          bit_end, last_stop, accept;

  assign bit_end   = (baud == BW'(CLKS_PER_BIT - 1));
  assign last_stop = (state == STOP) && bit_end && (stopcnt == 1'(STOP_BITS - 1));

  assign tx.txReady = (state == IDLE) || last_stop;
  assign tx.busy    = (state != IDLE);
  assign tx.done    = last_stop;
  assign tx.txOut   = txout_q;
  assign accept     = tx.txValid && tx.txReady;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      baud    <= '0;
      stopcnt <= 1'b0;
      txout_q <= 1'b1;
    end else begin
      state   <= nxt_state;
      shreg   <= nxt_shreg;
      bitcnt  <= nxt_bitcnt;
      baud    <= nxt_baud;
      stopcnt <= nxt_stopcnt;
      txout_q <= nxt_txout;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_shreg   = shreg;
    nxt_bitcnt  = bitcnt;
    nxt_stopcnt = stopcnt;
    nxt_baud    = bit_end ? '0 : baud + BW'(1);
    case (state)
      IDLE: begin
        nxt_baud = '0;
        if (accept) begin
          nxt_state = START;
          nxt_shreg = tx.txData;
        end
      end
      START: if (bit_end) nxt_state = SEND;
      SEND: begin
        if (bit_end) begin
          nxt_shreg  = {1'b0, shreg[7:1]};
          nxt_bitcnt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) nxt_state = STOP;
        end
      end
      STOP: begin
        if (last_stop) begin
          nxt_stopcnt = 1'b0;
          // A byte accepted on the last stop clock starts its frame immediately.
          if (accept) begin
            nxt_state = START;
            nxt_shreg = tx.txData;
          end else begin
            nxt_state = IDLE;
          end
        end else if (bit_end) begin
          nxt_stopcnt = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
    // txOut is registered, so it is loaded with the level of the state being entered.
    case (nxt_state)
      START:   nxt_txout = 1'b0;
      SEND:    nxt_txout = nxt_shreg[0];
      default: nxt_txout = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// Drives two transmitters (1 clk/bit 1 stop, 4 clk/bit 2 stop) with directed and random
// traffic and compares every cycle against a frame-position model and a loopback receiver.
module tb_uart_transmitter;
  localparam int C0 = 1, S0 = 1, C1 = 4, S1 = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] txData;
  logic       txValid;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  uart_transmitter_if u0 ();
  uart_transmitter_if u1 ();
  assign u0.txData = txData;  assign u0.txValid = txValid;
  assign u1.txData = txData;  assign u1.txValid = txValid;

  uart_transmitter #(.CLKS_PER_BIT(C0), .STOP_BITS(S0)) dut0 (.clk(clk), .rst(rst), .tx(u0.slave));
  uart_transmitter #(.CLKS_PER_BIT(C1), .STOP_BITS(S1)) dut1 (.clk(clk), .rst(rst), .tx(u1.slave));

  logic ob_out[2], ob_busy[2], ob_done[2], ob_rdy[2];
  assign ob_out[0] = u0.txOut;  assign ob_busy[0] = u0.busy;
  assign ob_done[0] = u0.done;  assign ob_rdy[0] = u0.txReady;
  assign ob_out[1] = u1.txOut;  assign ob_busy[1] = u1.busy;
  assign ob_done[1] = u1.done;  assign ob_rdy[1] = u1.txReady;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int ck(input int d);
    return (d == 0) ? C0 : C1;
  endfunction
  function automatic int flen(input int d);
    return (1 + 8 + ((d == 0) ? S0 : S1)) * ck(d);
  endfunction
  // Line level at clock k of a frame carrying byte b.
  function automatic logic fbit(input logic [7:0] b, input int k, input int c);
    int i;
    i = k / c;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    return 1'b1;
  endfunction
  function automatic int nextpos(input int p, input int len);
    if (p < 0 || p == len - 1) return -1;
    return p + 1;
  endfunction
  function automatic logic mrdy(input int p, input int len);
    return (p < 0) || (p == len - 1);
  endfunction

  // Model: position within the current frame (-1 = idle) and the byte in flight.
  int         pos[2] = '{-1, -1};
  logic [7:0] cur[2];
  logic [7:0] rx[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) pos[d] <= -1;
      else if (txValid && mrdy(pos[d], flen(d))) begin
        pos[d] <= 0;
        cur[d] <= txData;
      end else pos[d] <= nextpos(pos[d], flen(d));
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pos[d] < 0) begin
        chk($sformatf("txOut%0d", d), ob_out[d], 1'b1);
        chk($sformatf("busy%0d", d), ob_busy[d], 1'b0);
        chk($sformatf("done%0d", d), ob_done[d], 1'b0);
        chk($sformatf("txReady%0d", d), ob_rdy[d], 1'b1);
      end else begin
        chk($sformatf("txOut%0d", d), ob_out[d], fbit(cur[d], pos[d], ck(d)));
        chk($sformatf("busy%0d", d), ob_busy[d], 1'b1);
        chk($sformatf("done%0d", d), ob_done[d], pos[d] == flen(d) - 1);
        chk($sformatf("txReady%0d", d), ob_rdy[d], pos[d] == flen(d) - 1);
        // Loopback receiver: sample mid-bit, check the byte when done is expected.
        if (pos[d] / ck(d) >= 1 && pos[d] / ck(d) <= 8 && pos[d] % ck(d) == ck(d) / 2)
          rx[d][pos[d] / ck(d) - 1] <= ob_out[d];
        if (pos[d] == flen(d) - 1)
          chk($sformatf("rxbyte%0d", d), rx[d], cur[d]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic put(input logic [7:0] b, input int n);
    txValid = 1'b1;
    txData  = b;
    cyc(n);
    txValid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; txValid = 1'b0; txData = 8'h00;
    cyc(2);
    rst = 1'b1;
    cyc(20);
    put(8'hA5, 1);              cyc(60);
    put(8'h00, 1);
    put(8'hFF, 100);            cyc(60);
    put(8'h3C, 1);              cyc(60);
    // Abandon a frame during data bit 3 of the 1-clk/bit transmitter.
    put(8'hF0, 1);              cyc(4);
    rst = 1'b0;                 cyc(1);
    rst = 1'b1;
    put(8'h81, 1);              cyc(60);
    put(8'h5A, 1);              cyc(15);
    put(8'hC3, 1);              cyc(60);
    for (int i = 0; i < 2000; i++) begin
      txValid = ($urandom_range(0, 3) != 0);
      txData  = 8'($urandom);
      rst     = ($urandom_range(0, 199) != 0);
      cyc(1);
    end
    rst = 1'b1; txValid = 1'b0;
    cyc(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
